// File: rtl/spi_slave_regfile.sv
// SPI mode-0 target with a byte-wide register file.
// All SPI inputs are oversampled in the io_clock domain.
`timescale 1ns/1ps
module spi_slave_regfile #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                io_clock,
    input  logic                                io_reset_n,
    input  logic                                io_spi_sclk,
    input  logic                                io_spi_ss,
    input  logic                                io_spi_mosi,
    output logic                                io_spi_miso,
    output logic                                io_spi_miso_oe,
    input  logic [7:0]                          io_status,
    output logic [8*(2**ADDR_WIDTH-1)-1:0]      io_regs,
    output logic                                io_wr_strobe,
    output logic [ADDR_WIDTH-1:0]               io_wr_addr
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_prev, ss_prev;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

    // SS chain resets high so release never looks like a select
    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], io_spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], io_spi_ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], io_spi_mosi};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_rise   = ss_s & ~ss_prev;
    assign ss_fall   = ~ss_s & ss_prev;

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            rx_q, rx_d;
    logic [7:0]            tx_q, tx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  miso_q, miso_d;
    logic                  oe_q, oe_d;
    logic                  we;
    logic [7:0]            regs_q [DEPTH-1];

    logic [7:0]            shifted;
    logic [ADDR_WIDTH-1:0] cmd_addr, inc_addr;
    logic [7:0]            cmd_byte, inc_byte;

    assign shifted  = {rx_q, mosi_s};
    assign cmd_addr = shifted[ADDR_WIDTH-1:0];
    assign inc_addr = addr_q + ADDR_WIDTH'(1);
    assign cmd_byte = (cmd_addr == TOP) ? io_status : regs_q[cmd_addr];
    assign inc_byte = (inc_addr == TOP) ? io_status : regs_q[inc_addr];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        we        = 1'b0;
        if (ss_rise) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ss_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = 3'd0;
                    miso_d    = 1'b0;
                    oe_d      = 1'b1;
                end
                CMD: if (sclk_rise) begin
                    rx_d      = shifted[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d  = cmd_addr;
                        tx_d    = cmd_byte;
                        state_d = shifted[7] ? READ : WRITE;
                    end
                end
                WRITE: if (sclk_rise) begin
                    rx_d      = shifted[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        we     = (addr_q != TOP);
                        addr_d = inc_addr;
                    end
                end
                READ: if (sclk_fall) begin
                    miso_d    = tx_q[7];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    // last bit of this byte is out; queue the next byte
                    if (bit_cnt_q == 3'd7) begin
                        addr_d = inc_addr;
                        tx_d   = inc_byte;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
        end
    end

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            for (int k = 0; k < DEPTH - 1; k++) regs_q[k] <= '0;
            io_wr_strobe <= 1'b0;
            io_wr_addr   <= '0;
        end else begin
            io_wr_strobe <= we;
            if (we) begin
                regs_q[addr_q] <= shifted;
                io_wr_addr     <= addr_q;
            end
        end
    end

    for (genvar k = 0; k < DEPTH - 1; k++) begin : g_regs
        assign io_regs[8*k +: 8] = regs_q[k];
    end

    assign io_spi_miso    = miso_q;
    assign io_spi_miso_oe = oe_q;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile.
// Host bit-bangs SPI mode 0; writes and reads go through scoreboards.
`timescale 1ns/1ps
module tb_spi_slave_regfile;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sclk = 1'b0;
    logic         ss = 1'b1;
    logic         mosi = 1'b0;
    logic [7:0]   status = 8'h00;
    logic         miso, oe, strobe;
    logic [119:0] regs;
    logic [3:0]   wr_addr;

    spi_slave_regfile #(.ADDR_WIDTH(4), .SYNC_STAGES(2)) dut (
        .io_clock       (clk),
        .io_reset_n     (rst_n),
        .io_spi_sclk    (sclk),
        .io_spi_ss      (ss),
        .io_spi_mosi    (mosi),
        .io_spi_miso    (miso),
        .io_spi_miso_oe (oe),
        .io_status      (status),
        .io_regs        (regs),
        .io_wr_strobe   (strobe),
        .io_wr_addr     (wr_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] rq[$];
    logic [7:0] model [15];
    logic [7:0] r;

    function automatic logic [119:0] model_flat();
        logic [119:0] f;
        for (int k = 0; k < 15; k++) f[8*k +: 8] = model[k];
        return f;
    endfunction

    always @(negedge clk) begin
        wr_t w;
        if (rst_n && strobe) begin
            if (wq.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                w = wq.pop_front();
                check("wr_addr", wr_addr, w.a);
                check("wr_data", regs[8*w.a +: 8], w.d);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_wr(input int a, input logic [7:0] d);
        if (a != 15) begin
            wq.push_back('{a, d});
            model[a] = d;
        end
    endtask

    task automatic xfer(input logic [7:0] d, input int n,
                        output logic [7:0] q);
        q = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = d[7-i];
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            q = {q[6:0], miso};
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic spi_start();
        sclk = 1'b0;
        ss   = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_stop();
        sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic read_expect(input string tag, input logic [7:0] e);
        logic [7:0] q;
        rq.push_back(e);
        xfer(8'h00, 8, q);
        check(tag, q, rq.pop_front());
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_regs"}, regs, model_flat());
        check({tag, "_pending"}, wq.size(), 0);
    endtask

    initial begin
        for (int k = 0; k < 15; k++) model[k] = 8'h00;

        repeat (4) @(negedge clk);
        check("rst_regs", regs, 120'h0);
        check("rst_oe", oe, 0);
        check("rst_miso", miso, 0);
        check("rst_strobe", strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_regs", regs, 120'h0);
        check("idle_oe", oe, 0);

        // single write
        spi_start();
        check("sel_oe", oe, 1);
        xfer(8'h03, 8, r);
        check("miso_wr_cmd", r, 0);
        push_wr(3, 8'hA5);
        xfer(8'hA5, 8, r);
        check("miso_wr_data", r, 0);
        spi_stop();
        end_checks("t_single");
        check("desel_oe", oe, 0);

        // burst across status address and wrap
        spi_start();
        xfer(8'h0E, 8, r);
        push_wr(14, 8'h11);
        xfer(8'h11, 8, r);
        push_wr(15, 8'h22);
        xfer(8'h22, 8, r);
        push_wr(0, 8'h33);
        xfer(8'h33, 8, r);
        spi_stop();
        end_checks("t_burst");
        check("last_wr_addr", wr_addr, 0);

        // preload and read back
        spi_start();
        xfer(8'h05, 8, r);
        push_wr(5, 8'h5A);
        xfer(8'h5A, 8, r);
        push_wr(6, 8'hC3);
        xfer(8'hC3, 8, r);
        spi_stop();
        end_checks("t_preload");

        spi_start();
        xfer(8'h85, 8, r);
        read_expect("rd_reg5", 8'h5A);
        read_expect("rd_reg6", 8'hC3);
        check("rd_oe", oe, 1);
        spi_stop();
        end_checks("t_read");

        status = 8'h7E;
        spi_start();
        xfer(8'h8F, 8, r);
        read_expect("rd_status", 8'h7E);
        spi_stop();

        // wrap on read: 15 -> 0
        status = 8'h3C;
        spi_start();
        xfer(8'h8F, 8, r);
        read_expect("rd_wrap_status", 8'h3C);
        read_expect("rd_wrap_reg0", 8'h33);
        spi_stop();

        // aborted partial byte
        spi_start();
        xfer(8'h02, 8, r);
        xfer(8'hFF, 5, r);
        spi_stop();
        end_checks("t_abort");
        check("abort_oe", oe, 0);
        check("abort_miso", miso, 0);

        spi_start();
        xfer(8'h02, 8, r);
        push_wr(2, 8'h44);
        xfer(8'h44, 8, r);
        spi_stop();
        end_checks("t_after_abort");

        // reset in the middle of a read
        spi_start();
        xfer(8'h85, 8, r);
        xfer(8'h00, 4, r);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_oe", oe, 0);
        check("midrst_regs", regs, 120'h0);
        for (int k = 0; k < 15; k++) model[k] = 8'h00;
        sclk = 1'b0;
        ss   = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("postrst_oe", oe, 0);

        spi_start();
        xfer(8'h01, 8, r);
        push_wr(1, 8'h99);
        xfer(8'h99, 8, r);
        spi_stop();
        end_checks("t_after_rst");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
